spi_mem_rr_arbiter: RTL and testbench

Parametrised round-robin arbiter that grants exclusive access to the shared SPI memory controller among `NUM_CH` requesters. It replaces the fixed 4-channel `spi_mem_arbiter` and sits between the client ports and the SPI memory master. Grants are registered and one-hot, and every hand-off has a one-cycle chip-select gap. An optional hold-time limit preempts an owner that monopolises the bus while others wait.

---
 rtl/spi_mem_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_mem_rr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_rr_arbiter.sv
// Round-robin arbiter for the shared SPI memory master: registered one-hot grant with a one-cycle gap per hand-off.
// Optional hold-time preemption is enabled by defining SPI_MEM_ARB_TIMEOUT_EN.
module spi_mem_rr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int HOLD_MAX = 64,
  parameter int IDX_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              preempt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                grant_valid_q;
  logic [IDX_W-1:0]    grant_idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                pick_vld_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [IDX_W-1:0]    cand_s;

`ifdef SPI_MEM_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                preempt_q, preempt_d;
  logic                timeout_s;

  // Revoke once the owner has used its budget and someone else is waiting.
  assign timeout_s = (hold_q >= HOLD_W'(HOLD_MAX - 1)) && (|(req & ~grant_q));
`endif

  // Search from last+1 upward with wrap, so the previous owner is considered last.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = {IDX_W{1'b0}};
    cand_s     = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s = IDX_W'((int'(last_q) + i) % NUM_CH);
      if (!pick_vld_s && req[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = cand_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = grant_idx_q;
    last_d  = last_q;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_vld_s) begin
          state_d = ST_GRANT;
          grant_d = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx_s;
          idx_d   = pick_idx_s;
          last_d  = pick_idx_s;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
          hold_d  = {HOLD_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
          grant_d = {NUM_CH{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!req[grant_idx_q]) begin
          state_d = ST_GAP;
          grant_d = {NUM_CH{1'b0}};
        end
`ifdef SPI_MEM_ARB_TIMEOUT_EN
        else if (timeout_s) begin
          state_d   = ST_GAP;
          grant_d   = {NUM_CH{1'b0}};
          preempt_d = 1'b1;
        end else begin
          state_d = ST_GRANT;
          hold_d  = (hold_q == HOLD_W'(HOLD_MAX)) ? hold_q : hold_q + HOLD_W'(1);
        end
`else
        else begin
          state_d = ST_GRANT;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_CH{1'b0}};
      end
    endcase
  end

  // State and registered outputs; grant, valid and index update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= {NUM_CH{1'b0}};
      grant_valid_q <= 1'b0;
      grant_idx_q   <= {IDX_W{1'b0}};
      last_q        <= IDX_W'(NUM_CH - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
      grant_idx_q   <= idx_d;
      last_q        <= last_d;
    end
  end

`ifdef SPI_MEM_ARB_TIMEOUT_EN
  // Hold counter and preempt pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= {HOLD_W{1'b0}};
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_spi_mem_rr_arbiter.sv
// Scoreboard bench for spi_mem_rr_arbiter: a cycle-level reference model queues expected outputs,
// a monitor compares them one time unit after every rising edge.
module tb_spi_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int HM = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         preempt;

  spi_mem_rr_arbiter #(.NUM_CH(N), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         v;
    logic [1:0]   idx;
    logic         p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: owner (-1 = none), a pending-gap flag, round-robin pointer, grant cycles used.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_idx   = 0;
  int m_held  = 0;
  bit m_gap   = 1'b0;
  bit m_pre   = 1'b0;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
  bit timeout_en = 1'b1;
`else
  bit timeout_en = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_idx = 0; m_held = 0; m_gap = 1'b0; m_pre = 1'b0;
  endtask

  task automatic arbitrate(input logic [N-1:0] r);
    m_owner = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (m_owner < 0 && r[c]) begin
        m_owner = c; m_last = c; m_idx = c; m_held = 0;
      end
    end
  endtask

  // Model step on every active edge out of reset.
  initial begin
    forever begin
      logic [N-1:0] r;
      exp_t e;
      @(posedge clk);
      if (rst_n) begin
        r = req;
        m_pre = 1'b0;
        if (m_gap) begin
          m_gap = 1'b0;
          arbitrate(r);
        end else if (m_owner >= 0) begin
          m_held++;
          if (!r[m_owner]) begin
            m_owner = -1; m_gap = 1'b1;
          end else if (timeout_en && m_held >= HM && (r & ~(N'(1) << m_owner)) != '0) begin
            m_owner = -1; m_gap = 1'b1; m_pre = 1'b1;
          end
        end else begin
          arbitrate(r);
        end
        e.g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.v   = (m_owner >= 0);
        e.idx = 2'(m_idx);
        e.p   = m_pre;
        q.push_back(e);
      end
    end
  end

  // Monitor: compare whatever the model queued for this edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_valid", 32'(grant_valid), 32'(e.v));
        chk("grant_idx", 32'(grant_idx), 32'(e.idx));
        chk("preempt", 32'(preempt), 32'(e.p));
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input int cycles);
    @(negedge clk);
    req = v;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'h0);
    chk({tag, "_idx"}, 32'(grant_idx), 32'h0);
    chk({tag, "_preempt"}, 32'(preempt), 32'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    q.delete();
    model_reset();
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic grant, then asynchronous reset while granted.
    drive(4'b0001, 3);
    mid_reset();

    // Owner holds while others rise; hand-offs with one-cycle gaps.
    drive(4'b0001, 2);
    drive(4'b0111, 3);
    drive(4'b0110, 4);
    drive(4'b0100, 3);
    drive(4'b0000, 2);

    // Fairness and wrap: all requesting, each owner briefly releases after 3 cycles.
    drive(4'b1111, 2);
    for (int n = 0; n < 6; n++) begin
      repeat (3) @(negedge clk);
      if (m_owner >= 0) req[m_owner] = 1'b0;
      @(negedge clk);
      req = 4'b1111;
    end
    drive(4'b0000, 3);

    // Sole re-requester gets the grant back after the gap.
    drive(4'b0100, 3);
    drive(4'b0000, 1);
    drive(4'b0100, 3);
    drive(4'b0000, 3);

    // Contended hold: channel 3 arrives during owner 0's grant.
    mid_reset();
    drive(4'b0001, 2);
    drive(4'b1001, 14);
    drive(4'b1000, 3);
    drive(4'b0000, 3);

    // Long uncontended hold, then a late contender.
    drive(4'b0001, 52);
    drive(4'b0011, 4);
    drive(4'b0000, 3);

    // Randomised request traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [N-1:0] r;
      @(negedge clk);
      r = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      req = r;
    end
    drive(4'b0000, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
